// File: rtl/visbuffer.sv
`default_nettype none
// ============================================================================
//  Module      : visbuffer
//  Description : N-bank visibility frame buffer between the final-stage
//                accumulator and a host-facing AXI4-Stream. Complete frames
//                of TOTAL re/im pairs are written into a free bank.
//                Committed banks are streamed out in FIFO order at one beat
//                per cycle through a two-entry output skid.
//                Ports:
//                  clock, reset         - clock, synchronous active-high reset
//                  acc_valid_i/last_i   - accumulator word strobe / frame end
//                  acc_revis_i/imvis_i  - accumulator data
//                  m_tvalid_o/tready_i/tlast_o, m_revis_o/imvis_o - AXIS out
//                  level_o/full_o/empty_o - committed-bank occupancy
//                  overflow_o/frame_err_o - one-cycle drop pulses
//                  drops_o              - saturating dropped-frame count
//  Revision    : 1.0 - initial release
// ============================================================================
module visbuffer #(
    parameter int WIDTH = 32,
    parameter int TOTAL = 30,
    parameter int BANKS = 2,
    parameter int DBITS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         acc_valid_i,
    input  logic                         acc_last_i,
    input  logic [WIDTH-1:0]             acc_revis_i,
    input  logic [WIDTH-1:0]             acc_imvis_i,
    output logic                         m_tvalid_o,
    input  logic                         m_tready_i,
    output logic                         m_tlast_o,
    output logic [WIDTH-1:0]             m_revis_o,
    output logic [WIDTH-1:0]             m_imvis_o,
    output logic [$clog2(BANKS+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o,
    output logic                         frame_err_o,
    output logic [DBITS-1:0]             drops_o
);

    localparam int AW    = $clog2(TOTAL);
    localparam int BW    = $clog2(BANKS);
    localparam int LW    = $clog2(BANKS+1);
    localparam int DEPTH = BANKS * TOTAL;
    localparam int MW    = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [WIDTH-1:0] r_mem_re [DEPTH];
    logic [WIDTH-1:0] r_mem_im [DEPTH];

    logic [1:0]       r_state;
    logic [BW-1:0]    r_wbank;
    logic [AW-1:0]    r_waddr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;
    logic             r_frame_err;
    logic [DBITS-1:0] r_drops;

    // Read side: fetch pointer plus count of banks whose words have all been
    // fetched but whose last beat has not yet been handed off.
    logic [BW-1:0]    r_fbank;
    logic [AW-1:0]    r_faddr;
    logic [LW-1:0]    r_fetched;
    logic             r_pend;
    logic             r_rd_last;
    logic [WIDTH-1:0] r_rd_re;
    logic [WIDTH-1:0] r_rd_im;
    logic [1:0]       r_cnt;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_re;
    logic [WIDTH-1:0] r_out_im;
    logic             r_skid_last;
    logic [WIDTH-1:0] r_skid_re;
    logic [WIDTH-1:0] r_skid_im;

    logic             w_pop;
    logic             w_release;
    logic             w_no_room;
    logic             w_at_end;
    logic             w_commit;
    logic             w_ovf;
    logic             w_err;
    logic             w_we;
    logic             w_issue;
    logic             w_fetch_end;
    logic [2:0]       w_after;
    logic [LW-1:0]    w_level_nxt;
    logic [MW-1:0]    w_waddr;
    logic [MW-1:0]    w_raddr;

    assign w_pop     = m_tvalid_o && m_tready_i;
    assign w_release = w_pop && r_out_last;
    // Room is judged after any same-cycle release so a bank freed by the
    // final beat can be refilled immediately.
    assign w_no_room = ((r_level - LW'(w_release)) == LW'(BANKS));
    assign w_at_end  = (r_waddr == AW'(TOTAL-1));
    assign w_commit  = acc_valid_i && (r_state == S_FILL) && w_at_end && acc_last_i;
    assign w_ovf     = acc_valid_i && (r_state == S_IDLE) && w_no_room;
    // In FILL a frame is well formed only when last coincides with the end.
    assign w_err     = acc_valid_i &&
                       (((r_state == S_IDLE) && !w_no_room && acc_last_i) ||
                        ((r_state == S_FILL) && (acc_last_i != w_at_end)));
    assign w_we      = acc_valid_i &&
                       (((r_state == S_IDLE) && !w_no_room) || (r_state == S_FILL));
    assign w_level_nxt = r_level + LW'(w_commit) - LW'(w_release);

    // Issue a read only when its data is guaranteed a skid slot on arrival.
    assign w_after     = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue     = (r_level > r_fetched) && (w_after < 3'd2);
    assign w_fetch_end = (r_faddr == AW'(TOTAL-1));

    assign w_waddr = MW'(r_wbank) * MW'(TOTAL) + MW'(r_waddr);
    assign w_raddr = MW'(r_fbank) * MW'(TOTAL) + MW'(r_faddr);

    // Frame RAMs: not reset, synchronous one-cycle read.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem_re[w_waddr] <= acc_revis_i;
            r_mem_im[w_waddr] <= acc_imvis_i;
        end
        if (w_issue) begin
            r_rd_re <= r_mem_re[w_raddr];
            r_rd_im <= r_mem_im[w_raddr];
        end
    end

    // Write FSM, occupancy and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wbank     <= '0;
            r_waddr     <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            r_drops     <= '0;
        end else begin
            r_overflow  <= w_ovf;
            r_frame_err <= w_err;
            r_level     <= w_level_nxt;
            r_full      <= (w_level_nxt == LW'(BANKS));
            r_empty     <= (w_level_nxt == '0);
            if ((w_ovf || w_err) && (r_drops != '1)) begin
                r_drops <= r_drops + 1'b1;
            end
            if (acc_valid_i) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_no_room) begin
                            // A single-word dropped frame is already over.
                            r_state <= acc_last_i ? S_IDLE : S_DROP;
                        end else if (!acc_last_i) begin
                            r_state <= S_FILL;
                            r_waddr <= AW'(1);
                        end
                    end
                    S_FILL: begin
                        if (w_at_end) begin
                            r_waddr <= '0;
                            r_state <= acc_last_i ? S_IDLE : S_DROP;
                            if (acc_last_i) begin
                                r_wbank <= (r_wbank == BW'(BANKS-1)) ? '0 : r_wbank + 1'b1;
                            end
                        end else if (acc_last_i) begin
                            r_waddr <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_waddr <= r_waddr + 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (acc_last_i) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Fetch pointer and output skid (out register plus one spare entry).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fbank     <= '0;
            r_faddr     <= '0;
            r_fetched   <= '0;
            r_pend      <= 1'b0;
            r_rd_last   <= 1'b0;
            r_cnt       <= '0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_skid_last <= 1'b0;
            r_skid_re   <= '0;
            r_skid_im   <= '0;
        end else begin
            r_pend    <= w_issue;
            r_fetched <= r_fetched + LW'(w_issue && w_fetch_end) - LW'(w_release);
            if (w_issue) begin
                r_rd_last <= w_fetch_end;
                if (w_fetch_end) begin
                    r_faddr <= '0;
                    r_fbank <= (r_fbank == BW'(BANKS-1)) ? '0 : r_fbank + 1'b1;
                end else begin
                    r_faddr <= r_faddr + 1'b1;
                end
            end

            if ((r_cnt == 2'd0) || (w_pop && (r_cnt == 2'd1))) begin
                if (r_pend) begin
                    r_out_last <= r_rd_last;
                    r_out_re   <= r_rd_re;
                    r_out_im   <= r_rd_im;
                end
            end else if (w_pop && (r_cnt == 2'd2)) begin
                r_out_last <= r_skid_last;
                r_out_re   <= r_skid_re;
                r_out_im   <= r_skid_im;
            end

            if (r_pend && (((r_cnt == 2'd1) && !w_pop) || ((r_cnt == 2'd2) && w_pop))) begin
                r_skid_last <= r_rd_last;
                r_skid_re   <= r_rd_re;
                r_skid_im   <= r_rd_im;
            end

            r_cnt <= w_after[1:0];
        end
    end

    assign m_tvalid_o  = (r_cnt != 2'd0);
    assign m_tlast_o   = r_out_last;
    assign m_revis_o   = r_out_re;
    assign m_imvis_o   = r_out_im;
    assign level_o     = r_level;
    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;
    assign drops_o     = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_visbuffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_visbuffer
//  Description : Self-checking bench for visbuffer (WIDTH=32, TOTAL=4,
//                BANKS=2). A frame-level reference model tracks committed
//                frames and expected output beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_visbuffer;

    localparam int WIDTH = 32;
    localparam int TOTAL = 4;
    localparam int BANKS = 2;
    localparam int DBITS = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             acc_valid_i = 1'b0;
    logic             acc_last_i = 1'b0;
    logic [WIDTH-1:0] acc_revis_i = '0;
    logic [WIDTH-1:0] acc_imvis_i = '0;
    logic             m_tvalid_o;
    logic             m_tready_i = 1'b0;
    logic             m_tlast_o;
    logic [WIDTH-1:0] m_revis_o;
    logic [WIDTH-1:0] m_imvis_o;
    logic [1:0]       level_o;
    logic             full_o;
    logic             empty_o;
    logic             overflow_o;
    logic             frame_err_o;
    logic [DBITS-1:0] drops_o;

    visbuffer #(.WIDTH(WIDTH), .TOTAL(TOTAL), .BANKS(BANKS), .DBITS(DBITS)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .acc_valid_i(acc_valid_i),
        .acc_last_i (acc_last_i),
        .acc_revis_i(acc_revis_i),
        .acc_imvis_i(acc_imvis_i),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tlast_o  (m_tlast_o),
        .m_revis_o  (m_revis_o),
        .m_imvis_o  (m_imvis_o),
        .level_o    (level_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .overflow_o (overflow_o),
        .frame_err_o(frame_err_o),
        .drops_o    (drops_o)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             last;
    } beat_t;

    beat_t            exp_q [$];
    logic [WIDTH-1:0] wq_re [$];
    logic [WIDTH-1:0] wq_im [$];
    int               m_level = 0;
    int               m_drops = 0;
    int               m_mode  = 0;   // 0 between frames, 1 collecting, 2 discarding
    logic             m_ovf = 1'b0;
    logic             m_err = 1'b0;
    logic             armed = 1'b0;
    logic             after_rst = 1'b0;
    logic             prev_stall = 1'b0;
    beat_t            prev_b;
    beat_t            b;
    int               beats = 0;
    int               lasts = 0;
    int               ready_mode = 0; // 0 low, 1 high, 2 random

    task automatic bump_drops();
        if (m_drops < (1 << DBITS) - 1) m_drops++;
    endtask

    always @(negedge clock) begin
        if (armed) begin
            check("level", level_o, m_level);
            check("full", full_o, (m_level == BANKS));
            check("empty", empty_o, (m_level == 0));
            check("overflow", overflow_o, m_ovf);
            check("frame_err", frame_err_o, m_err);
            check("drops", drops_o, m_drops);
            if (after_rst) begin
                check("rst_tvalid", m_tvalid_o, 0);
                check("rst_tlast", m_tlast_o, 0);
                check("rst_re", m_revis_o, 0);
                check("rst_im", m_imvis_o, 0);
            end
            if (prev_stall) begin
                check("hold_tvalid", m_tvalid_o, 1);
                check("hold_re", m_revis_o, prev_b.re);
                check("hold_im", m_imvis_o, prev_b.im);
                check("hold_tlast", m_tlast_o, prev_b.last);
            end
        end
        m_ovf = 1'b0;
        m_err = 1'b0;
        if (reset) begin
            m_level = 0;
            m_drops = 0;
            m_mode  = 0;
            wq_re.delete();
            wq_im.delete();
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (m_tvalid_o && m_tready_i) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_tvalid_o, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_re", m_revis_o, b.re);
                    check("beat_im", m_imvis_o, b.im);
                    check("beat_tlast", m_tlast_o, b.last);
                    if (b.last) begin
                        m_level--;
                        lasts++;
                    end
                end
            end
            if (acc_valid_i) begin
                case (m_mode)
                    0: begin
                        if (m_level == BANKS) begin
                            m_ovf = 1'b1;
                            bump_drops();
                            m_mode = acc_last_i ? 0 : 2;
                        end else begin
                            wq_re.delete();
                            wq_im.delete();
                            wq_re.push_back(acc_revis_i);
                            wq_im.push_back(acc_imvis_i);
                            if (acc_last_i) begin
                                m_err = 1'b1;
                                bump_drops();
                            end else begin
                                m_mode = 1;
                            end
                        end
                    end
                    1: begin
                        wq_re.push_back(acc_revis_i);
                        wq_im.push_back(acc_imvis_i);
                        if (wq_re.size() == TOTAL) begin
                            if (acc_last_i) begin
                                for (int i = 0; i < TOTAL; i++) begin
                                    exp_q.push_back('{re: wq_re[i], im: wq_im[i], last: (i == TOTAL-1)});
                                end
                                m_level++;
                                m_mode = 0;
                            end else begin
                                m_err = 1'b1;
                                bump_drops();
                                m_mode = 2;
                            end
                        end else if (acc_last_i) begin
                            m_err = 1'b1;
                            bump_drops();
                            m_mode = 0;
                        end
                    end
                    default: begin
                        if (acc_last_i) m_mode = 0;
                    end
                endcase
            end
            prev_stall = m_tvalid_o && !m_tready_i;
            prev_b = '{re: m_revis_o, im: m_imvis_o, last: m_tlast_o};
        end
        after_rst = reset;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 2) m_tready_i = $urandom_range(0, 1);
            else                 m_tready_i = (ready_mode == 1);
        end
    end

    task automatic send_frame(input int n, input int last_at, input int base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                acc_valid_i = 1'b0;
                acc_last_i  = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            acc_valid_i = 1'b1;
            acc_last_i  = (i == last_at - 1);
            acc_revis_i = base + i + 1;
            acc_imvis_i = base + 101 + i;
            tick();
        end
        acc_valid_i = 1'b0;
        acc_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(empty_o && !m_tvalid_o) && n < 500) begin
            tick();
            n++;
        end
        check("drained", (empty_o && !m_tvalid_o), 1);
    endtask

    initial begin
        int n;
        int d0;
        int l0;
        int b0;
        int len;

        reset = 1'b1;
        tick();
        armed = 1'b1;
        tick();
        tick();
        check("rst_empty", empty_o, 1);
        check("rst_level", level_o, 0);
        reset = 1'b0;
        tick();

        // 1: single frame, ready high, first-beat latency
        ready_mode = 1;
        tick();
        send_frame(4, 4, 0, 0);
        check("t1_level_up", level_o, 1);
        n = 0;
        while (!m_tvalid_o && n < 10) begin
            tick();
            n++;
        end
        check("t1_first_beat_latency", n, 2);
        check("t1_first_re", m_revis_o, 1);
        check("t1_first_im", m_imvis_o, 101);
        wait_drain();

        // 2: three frames while stalled -> one overflow
        ready_mode = 0;
        tick();
        tick();
        d0 = drops_o;
        send_frame(4, 4, 10, 0);
        send_frame(4, 4, 20, 0);
        check("t2_full", full_o, 1);
        send_frame(4, 4, 30, 0);
        tick();
        check("t2_drops", drops_o, d0 + 1);
        ready_mode = 1;
        wait_drain();

        // 3: random back-pressure over two frames
        ready_mode = 2;
        l0 = lasts;
        send_frame(4, 4, 40, 1);
        send_frame(4, 4, 50, 1);
        wait_drain();
        check("t3_tlast_count", lasts - l0, 2);

        // 4: short frame then a good one
        ready_mode = 1;
        d0 = drops_o;
        send_frame(2, 2, 60, 0);
        send_frame(4, 4, 70, 0);
        wait_drain();
        check("t4_drops", drops_o, d0 + 1);

        // 5: over-long frame then a good one
        d0 = drops_o;
        send_frame(6, 6, 80, 0);
        send_frame(4, 4, 90, 0);
        wait_drain();
        check("t5_drops", drops_o, d0 + 1);

        // 6: reset in the middle of streaming two banks
        ready_mode = 0;
        tick();
        tick();
        send_frame(4, 4, 110, 0);
        send_frame(4, 4, 120, 0);
        tick();
        check("t6_level", level_o, 2);
        ready_mode = 1;
        b0 = beats;
        n = 0;
        while (beats < b0 + 2 && n < 50) begin
            tick();
            n++;
        end
        check("t6_beats_before_reset", (beats >= b0 + 2), 1);
        reset = 1'b1;
        ready_mode = 0;
        tick();
        check("t6_rst_tvalid", m_tvalid_o, 0);
        check("t6_rst_level", level_o, 0);
        check("t6_rst_empty", empty_o, 1);
        reset = 1'b0;
        ready_mode = 1;
        send_frame(4, 4, 130, 0);
        wait_drain();

        // random frames with random back-pressure
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : TOTAL;
            send_frame(len, len, 200 + f * 10, $urandom_range(0, 1));
        end
        ready_mode = 1;
        wait_drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/visbuffer.md
# visbuffer

Parametrised, single-clock, N-bank visibility output buffer that sits between the final-stage visibility accumulator and the host-facing AXI4-Stream. Each complete frame of `TOTAL` real/imaginary visibility pairs is written into a free bank. Committed banks are streamed out in FIFO order at one beat per cycle. Over the previous two-bank sketch it adds:

- bank-occupancy tracking and full/empty status;
- frame-length checking;
- overflow dropping with a drop counter;
- a stall-tolerant output stage.

## Interface
Parameters:
- `WIDTH`, 32: bit-width of each visibility component (accumulator width).
- `TOTAL`, 30: visibilities per frame (CORES*TRATE); must be ≥2.
- `BANKS`, 2: number of frame banks; must be ≥2.
- `DBITS`, 16: width of the dropped-frame counter.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `acc_valid_i`  in  1  input word valid (no back-pressure).
- `acc_last_i`  in  1  marks the final word of a frame.
- `acc_revis_i`  in  WIDTH  real visibility.
- `acc_imvis_i`  in  WIDTH  imaginary visibility.
- `m_tvalid_o`  out  1  AXI4-Stream valid.
- `m_tready_i`  in  1  AXI4-Stream ready.
- `m_tlast_o`  out  1  last beat of a frame.
- `m_revis_o`  out  WIDTH  real visibility out.
- `m_imvis_o`  out  WIDTH  imaginary visibility out.
- `level_o`  out  clog2(BANKS+1)  committed, unread banks.
- `full_o`  out  1  `level_o == BANKS`.
- `empty_o`  out  1  `level_o == 0`.
- `overflow_o`  out  1  one-cycle pulse when a frame is dropped because no bank is free.
- `frame_err_o`  out  1  one-cycle pulse on a length-mismatched frame.
- `drops_o`  out  DBITS  saturating count of dropped frames (overflow plus error).

## Operation
**Storage**
- Two `WIDTH`-bit RAMs, each `BANKS*TOTAL` deep, addressed `{bank, addr}`.
- Synchronous read, 1-cycle latency.
- Contents are not cleared by reset.

**Write FSM**
- `IDLE`: the first `acc_valid_i` word starts a frame.
  - If `level_o == BANKS` (counted *after* any same-cycle release), go to `DROP`: pulse `overflow_o` and increment `drops_o`.
  - Otherwise write the word at `addr 0` of `wbank` and go to `FILL`. A single-word frame is handled as the `FILL` error case below.
- `FILL`: each valid word is written at `waddr`, then `waddr` increments.
  - Word with `waddr == TOTAL-1` **and** `acc_last_i`: commit the frame. `wbank` advances modulo `BANKS`, `level` increments, go to `IDLE`.
  - `acc_last_i` with `waddr < TOTAL-1`: pulse `frame_err_o`, increment `drops_o`, leave `wbank` unchanged, go to `IDLE`.
  - `waddr == TOTAL-1` without `acc_last_i`: pulse `frame_err_o`, increment `drops_o`, go to `DROP`.
- `DROP`: discard words until a valid word with `acc_last_i`, then go to `IDLE`.

**Read side**
- `rbank` and `raddr` run FIFO order over committed banks.
- Prefetch keeps a 2-entry output skid, so throughput is 1 beat/cycle while `m_tready_i` is high.
- `m_tlast_o` is asserted on the beat with `raddr == TOTAL-1`.
- The `m_tvalid_o && m_tready_i && m_tlast_o` handshake releases the bank: `rbank` advances and `level` decrements.
- Simultaneous commit and release leaves `level` unchanged.

**AXI4-Stream rules**
- Once `m_tvalid_o` is asserted, it and the data stay stable until accepted.
- A bank is never overwritten before its release.

**Counter:** `drops_o` saturates at all-ones.

## Timing
- Reset (synchronous, one or more cycles) returns every output to 0:
  - `m_tvalid_o`, `m_tlast_o`, `m_revis_o`, `m_imvis_o`, `level_o`, `full_o`, `overflow_o`, `frame_err_o` and `drops_o` are 0.
  - `empty_o` is 1.
- Reset mid-frame or mid-stream discards the partial frame and all committed banks. The write FSM returns to `IDLE` and all pointers return to 0.
- Commit latency: `level_o` increments on the cycle after the last word is sampled.
- First-beat latency: `m_tvalid_o` rises 2 cycles after `level_o` goes 0→1, with `m_tready_i` held high.
- Continuous `m_tready_i` gives `TOTAL` consecutive beats. Back-to-back committed banks stream with no bubble.
- `full_o`, `empty_o` and `level_o` are registered and update the cycle after the commit or release.
- `overflow_o` and `frame_err_o` pulse the cycle after the offending word is sampled.

## Test plan
Bench parameters: `WIDTH=32`, `TOTAL=4`, `BANKS=2`.

1. One frame (re = 1..4, im = 101..104), `m_tready_i` = 1: `level_o` 0→1→0, four beats 1..4 / 101..104, `m_tlast_o` on beat 4, first beat 2 cycles after commit.
2. Three frames back-to-back, `m_tready_i` = 0: `full_o` = 1 after frame 2, `overflow_o` pulses once, `drops_o` = 1. Then set ready = 1: frames 1 and 2 stream in order, `empty_o` returns to 1.
3. Random `m_tready_i` at 50% over 2 frames: data sequence is intact, each beat is held stable while stalled, `m_tlast_o` appears exactly twice.
4. Short frame (`acc_last_i` on word 2), then a good frame: `frame_err_o` pulses, `drops_o` = 1, only the good frame is output.
5. Six-word frame with no last until word 6: `frame_err_o` pulses after word 4, words 5–6 are discarded, the next frame is output correctly.
6. Reset asserted mid-stream (beat 2 of 4, `level_o` = 2): all outputs return to reset values. The next frame streams from bank 0 with correct data.
